// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction stage sequencer: state encodings,
// default handshake timeout and a small state classification helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EX   = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_IDLE = 3'b101,
        ST_ERR  = 3'b110,
        ST_BAD  = 3'b111
    } stage_e;

    localparam int TIMEOUT_DEFAULT = 16;

    // IF and MEM are the only states that wait on a memory handshake.
    function automatic logic is_wait_state(input stage_e s);
        return (s == ST_IF) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake wait counter: counts cycles spent waiting and flags the cycle in
// which the wait limit is reached without an acknowledge.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic tick,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Cycle counter, held at zero while no handshake is in progress.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (tick && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

    // count is (cycle - 1), so this is the last permitted cycle; an ack here wins.
    assign expired = tick && !ack && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: steps the datapath through
// IF/ID/EX/MEM/WB with timed memory handshakes, single-step and run counters.
module stage_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        step_mode,
    input  logic        step,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        mem_access,
    input  logic        reg_write,
    output logic [2:0]  state,
    output logic        imem_req,
    output logic        ir_we,
    output logic        cu_en,
    output logic        alu_en,
    output logic        pc_we,
    output logic        dmem_req,
    output logic        rf_we,
    output logic        retire,
    output logic        busy,
    output logic        err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    stage_e cur;
    stage_e nxt;
    logic   timer_tick;
    logic   timer_clear;
    logic   timer_ack;
    logic   expired;

    assign state = cur;

    // Timer runs only inside IF/MEM, so every entry starts from zero.
    always_comb begin
        timer_tick  = is_wait_state(cur);
        timer_clear = reset || !timer_tick;
        if (cur == ST_IF) begin
            timer_ack = imem_ack;
        end else begin
            timer_ack = dmem_ack;
        end
    end

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .ack     (timer_ack),
        .expired (expired)
    );

    // Next-state selection; acks are only looked at in their own wait state.
    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (en && (!step_mode || step)) nxt = ST_IF;
                else                            nxt = ST_IDLE;
            end
            ST_IF: begin
                if (imem_ack)     nxt = ST_ID;
                else if (expired) nxt = ST_ERR;
                else              nxt = ST_IF;
            end
            ST_ID:  nxt = ST_EX;
            ST_EX: begin
                if (mem_access) nxt = ST_MEM;
                else            nxt = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack)     nxt = ST_WB;
                else if (expired) nxt = ST_ERR;
                else              nxt = ST_MEM;
            end
            ST_WB: begin
                if (en && !step_mode) nxt = ST_IF;
                else                  nxt = ST_IDLE;
            end
            ST_ERR:  nxt = ST_ERR;
            default: nxt = ST_IDLE;
        endcase
    end

    // State, registered strobes decoded from the next state, and run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= ST_IDLE;
            imem_req  <= 1'b0;
            cu_en     <= 1'b0;
            alu_en    <= 1'b0;
            pc_we     <= 1'b0;
            dmem_req  <= 1'b0;
            retire    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cur       <= nxt;
            imem_req  <= (nxt == ST_IF);
            cu_en     <= (nxt == ST_ID);
            alu_en    <= (nxt == ST_EX);
            pc_we     <= (nxt == ST_EX);
            dmem_req  <= (nxt == ST_MEM);
            retire    <= (nxt == ST_WB);
            busy      <= !((nxt == ST_IDLE) || (nxt == ST_ERR));
            err       <= (nxt == ST_ERR);
            if (busy) cycle_cnt <= cycle_cnt + 32'd1;
            else      cycle_cnt <= cycle_cnt;
            if (retire) instr_cnt <= instr_cnt + 32'd1;
            else        instr_cnt <= instr_cnt;
        end
    end

    // These two depend on same-cycle inputs and are qualified by registered strobes.
    assign ir_we = imem_req & imem_ack;
    assign rf_we = retire & reg_write;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus a randomized
// instruction stream scored against a per-instruction latency model.
module tb_stage_sequencer;

    localparam int TO = 16;
    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011;
    localparam logic [2:0] S_WB = 3'b100, S_IDLE = 3'b101, S_ERR = 3'b110;

    logic clk = 1'b0;
    logic reset = 1'b0, en = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic imem_ack = 1'b0, dmem_ack = 1'b0, mem_access = 1'b0, reg_write = 1'b0;
    logic [2:0]  state;
    logic        imem_req, ir_we, cu_en, alu_en, pc_we, dmem_req, rf_we, retire, busy, err;
    logic [31:0] cycle_cnt, instr_cnt;

    int errors = 0;
    int checks = 0;
    int retire_seen = 0;
    bit onehot_on = 1'b0;
    bit sb_on = 1'b0;

    typedef struct {
        logic        rf;
        logic [31:0] cyc;
        logic [31:0] icnt;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk(clk), .reset(reset), .en(en), .step_mode(step_mode), .step(step),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mem_access(mem_access),
        .reg_write(reg_write), .state(state), .imem_req(imem_req), .ir_we(ir_we),
        .cu_en(cu_en), .alu_en(alu_en), .pc_we(pc_we), .dmem_req(dmem_req),
        .rf_we(rf_we), .retire(retire), .busy(busy), .err(err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {22'd0, imem_req, ir_we, cu_en, alu_en, pc_we, dmem_req, rf_we, retire, busy, err};
    endfunction

    // Monitor: strobe exclusivity every cycle and scoreboard pop on each retire.
    always @(negedge clk) begin
        if (retire === 1'b1) retire_seen++;
        if (onehot_on) check("strobe_onehot", 32'($countones({cu_en, alu_en, rf_we}) <= 1), 32'd1);
        if (sb_on && (retire === 1'b1)) begin
            check("sb_expected_retire", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_state_wb", 32'(state), 32'(S_WB));
                check("sb_rf_we", 32'(rf_we), 32'(e.rf));
                check("sb_cycle_cnt", cycle_cnt, e.cyc);
                check("sb_instr_cnt", instr_cnt, e.icnt);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; step = 1'b0; step_mode = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; mem_access = 1'b0; reg_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Randomized free-running stream; en drops during EX of the last instruction.
    task automatic drive_rand(input int n);
        logic [31:0] cum;
        cum = 32'd0;
        for (int k = 0; k < n; k++) begin
            int  di, dd, lat;
            bit  mem, rw, last;
            exp_t e;
            di   = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, TO - 1));
            dd   = int'($urandom_range(0, 6));
            mem  = ($urandom_range(0, 1) == 1);
            rw   = ($urandom_range(0, 1) == 1);
            last = (k == n - 1);
            lat  = (di + 1) + 2 + (mem ? dd + 1 : 0) + 1;
            e.rf   = rw;
            e.cyc  = cum + 32'(lat) - 32'd1;
            e.icnt = 32'(k);
            exp_q.push_back(e);
            cum = cum + 32'(lat);
            for (int c = 0; c <= di; c++) begin
                @(negedge clk);
                imem_ack   = (c == di);
                dmem_ack   = ($urandom_range(0, 1) == 1);
                mem_access = ($urandom_range(0, 1) == 1);
                reg_write  = ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            imem_ack = ($urandom_range(0, 1) == 1);
            dmem_ack = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            imem_ack = ($urandom_range(0, 1) == 1);
            dmem_ack = ($urandom_range(0, 1) == 1);
            mem_access = mem;
            reg_write  = rw;
            if (last) en = 1'b0;
            if (mem) begin
                for (int c = 0; c <= dd; c++) begin
                    @(negedge clk);
                    imem_ack = ($urandom_range(0, 1) == 1);
                    dmem_ack = (c == dd);
                end
            end
            @(negedge clk);
            imem_ack = ($urandom_range(0, 1) == 1);
            dmem_ack = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        logic [2:0] pat [4];
        int base;
        pat[0] = S_IF; pat[1] = S_ID; pat[2] = S_EX; pat[3] = S_WB;

        // Reset state
        do_reset();
        onehot_on = 1'b1;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_strobes", strobes(), 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instr_cnt", instr_cnt, 32'd0);

        // Acks tied high, no memory access: 4-cycle instructions back to back
        en = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("run_state_seq", 32'(state), 32'(pat[i % 4]));
        end
        @(negedge clk);
        check("run_cycle_cnt40", cycle_cnt, 32'd40);
        check("run_instr_cnt10", instr_cnt, 32'd10);

        // Ack in IF cycle TIMEOUT is accepted; missing ack faults on cycle TIMEOUT+1
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            check("to_wait_if", 32'(state), 32'(S_IF));
            if (k == TO) imem_ack = 1'b1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        check("to_ack_last_cycle", 32'(state), 32'(S_ID));
        @(negedge clk);
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            check("to_wait_if2", 32'(state), 32'(S_IF));
        end
        @(negedge clk);
        check("to_err_state", 32'(state), 32'(S_ERR));
        check("to_err_strobes", strobes(), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            step = ~step; en = ~en; step_mode = ~step_mode; imem_ack = 1'b1; dmem_ack = 1'b1;
            check("to_err_sticky", 32'(state), 32'(S_ERR));
        end
        do_reset();
        check("to_reset_clears", 32'(state), 32'(S_IDLE));
        check("to_reset_err", 32'(err), 32'd0);

        // Single-step mode: three pulses, a busy-time pulse ignored
        do_reset();
        step_mode = 1'b1; en = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; reg_write = 1'b1;
        base = retire_seen;
        repeat (3) @(negedge clk);
        check("step_wait_idle", 32'(state), 32'(S_IDLE));
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); step = 1'b1;
            @(negedge clk); step = 1'b0;
            @(negedge clk); step = 1'b1;
            @(negedge clk); step = 1'b0;
            repeat (6) @(negedge clk);
            check("step_back_idle", 32'(state), 32'(S_IDLE));
        end
        check("step_retires", 32'(retire_seen - base), 32'd3);
        check("step_instr_cnt", instr_cnt, 32'd3);

        // Randomized stream against the scoreboard
        do_reset();
        sb_on = 1'b1;
        en = 1'b1;
        drive_rand(30);
        @(negedge clk);
        check("en_drop_idle", 32'(state), 32'(S_IDLE));
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;

        // Reset during MEM with an ack in the same cycle
        do_reset();
        en = 1'b1; imem_ack = 1'b1; mem_access = 1'b1;
        repeat (4) @(negedge clk);
        check("mem_reached", 32'(state), 32'(S_MEM));
        reset = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        check("mem_reset_state", 32'(state), 32'(S_IDLE));
        check("mem_reset_strobes", strobes() & ~32'd32, 32'd0);
        check("mem_reset_cycle_cnt", cycle_cnt, 32'd0);
        check("mem_reset_instr_cnt", instr_cnt, 32'd0);

        // cycle_cnt wrap
        do_reset();
        en = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        @(negedge clk);
        check("cycle_cnt_wrap", cycle_cnt, 32'd0);
        @(negedge clk);
        check("cycle_cnt_after_wrap", cycle_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
